pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max consecutive memory-wait cycles before fault, legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-006 id_ex_mem_read  in  1  instruction in EX is a load.
REQ-007 id_ex_reg_dest  in  5  destination register of the instruction in EX.
REQ-008 ex_redirect  in  1  EX has resolved a taken branch, jal or jalr.
REQ-009 mem_req  in  1  MEM stage holds a valid load/store.
REQ-010 mem_ready  in  1  data memory completes the MEM access this cycle.
REQ-011 pc_write  out  1  PC update enable.
REQ-012 if_id_write  out  1  IF/ID register load enable.
REQ-013 if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  bubble-insert into the named register.
REQ-014 id_ex_hold, ex_mem_hold  out  1 each  hold current contents of the named register.
REQ-015 mem_timeout  out  1  sticky fault flag.
REQ-016 stall_cycles, redirect_count  out  CNT_W each  performance counters.

Function
REQ-017 State machine, encoded states: RUN, MEM_WAIT, FAULT.
REQ-018 freeze = mem_req && !mem_ready, evaluated combinationally in RUN and MEM_WAIT.
REQ-019 load_use = id_ex_mem_read && id_ex_reg_dest!=0 && (id_ex_reg_dest==id_rs1 || id_ex_reg_dest==id_rs2).
REQ-020 Priority, highest first: FAULT, freeze, ex_redirect, load_use, none.
REQ-021 Freeze cycle: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, mem_wb_flush=1, other flushes 0.
REQ-022 Redirect cycle: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, holds 0, mem_wb_flush=0.
REQ-023 Load-use cycle: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, holds 0, mem_wb_flush=0.
REQ-024 No-hazard cycle: pc_write=1, if_id_write=1, all flushes and holds 0.
REQ-025 Redirect and load_use together: redirect response only (stalled ID instruction is squashed).
REQ-026 ex_redirect during freeze: not acted on; controller applies redirect in first non-freeze cycle if still asserted.
REQ-027 RUN -> MEM_WAIT when freeze; wait_cnt loads 1.
REQ-028 MEM_WAIT: mem_ready=1 -> RUN same edge, that cycle treated as non-freeze (REQ-020 continues at redirect).
REQ-029 MEM_WAIT: freeze and wait_cnt==TIMEOUT-1 -> FAULT; else wait_cnt increments.
REQ-030 mem_req deasserting in MEM_WAIT -> RUN, no fault.
REQ-031 FAULT: outputs as freeze (REQ-021), mem_timeout=1, exits only on reset.
REQ-032 stall_cycles increments each cycle pc_write==0 outside reset, including FAULT; saturates at all-ones.
REQ-033 redirect_count increments once per cycle REQ-022 applies; saturates at all-ones.
REQ-034 Single-cycle mem access (mem_req && mem_ready): no stall, state stays RUN.

Reset
REQ-035 reset high on posedge: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, redirect_count=0.
REQ-036 While reset high, outputs forced: pc_write=0, if_id_write=0, all flushes=1, holds=0; counters do not count.
REQ-037 Reset mid-MEM_WAIT or in FAULT: takes effect same edge; first post-reset cycle evaluated from RUN.

Verification
REQ-038 id_ex_mem_read=1, rd=5, rs2=5, one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1.
REQ-039 rd=0 matching rs1=0 with load -> no stall, pc_write=1.
REQ-040 mem_req=1, mem_ready low 3 cycles then high -> 3 freeze cycles, MEM_WAIT, RUN after ready edge, stall_cycles=3.
REQ-041 ex_redirect with load_use same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; redirect_count=1.
REQ-042 TIMEOUT=4, mem_ready held low -> FAULT after 4th freeze cycle, mem_timeout=1 sticky; reset clears to RUN, counters 0.
REQ-043 ex_redirect held during 2-cycle freeze -> no flush during freeze, redirect response on ready cycle, redirect_count=1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Resolves memory freezes, EX redirects and load-use stalls into per-register
// enable/flush/hold controls, detects stuck memory accesses and keeps
// saturating performance counters for stall cycles and redirects.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_reg_dest,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  // Last wait count that may still be followed by another wait cycle;
  // reaching it while still frozen means the access has timed out.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  logic freeze;
  logic load_use;
  logic redirect_fire;

  // Hazard detection: a pending memory access freezes the back end, and a
  // load in EX feeding a source in ID needs one bubble (x0 never hazards).
  always_comb begin
    freeze   = 1'b0;
    load_use = 1'b0;
    if (state_q != FAULT) begin
      freeze = mem_req && !mem_ready;
    end
    if (id_ex_mem_read && (id_ex_reg_dest != 5'd0) &&
        ((id_ex_reg_dest == id_rs1) || (id_ex_reg_dest == id_rs2))) begin
      load_use = 1'b1;
    end
  end

  // Next-state logic: track consecutive freeze cycles and trap to FAULT
  // when memory never answers.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          // Either memory answered or the request went away; this cycle
          // is handled as an ordinary non-freeze cycle.
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = FAULT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      FAULT: begin
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Output decode in priority order: reset, fault/freeze, redirect,
  // load-use, then free-running.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    redirect_fire = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if ((state_q == FAULT) || freeze) begin
      // Front end and EX/MEM stand still; WB gets a bubble so the stuck
      // access is not retired twice. A redirect waits for the thaw.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_hold   = 1'b1;
      ex_mem_hold  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      // Squashes the wrong-path instructions in IF/ID and ID/EX, which
      // includes any instruction that a load-use stall would have held.
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      redirect_fire = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating performance counters; reset keeps them at zero.
  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (!pc_write && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (redirect_fire && !(&redirect_count_q)) begin
      redirect_count_d = redirect_count_q + 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      wait_cnt_q       <= 8'd0;
      mem_timeout_q    <= 1'b0;
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      mem_timeout_q    <= mem_timeout_d;
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign mem_timeout    = mem_timeout_q;
  assign stall_cycles   = stall_cycles_q;
  assign redirect_count = redirect_count_q;

endmodule
